// File: rtl/hsv2rgb_stream.sv
// hsv2rgb_stream
//   Streaming HSV-to-RGB converter with a fixed 6-stage integer pipeline.
//   Each enabled clock accepts one HSV pixel and emits the pixel that entered
//   five enabled edges earlier. A valid flag, a run-time mode and a sideband
//   bus travel with each beat.
//
// Ports
//   clk        system clock
//   rst        synchronous, active-high reset (clears valids and outputs)
//   en         pipeline enable; 0 holds every register, outputs included
//   in_valid   input pixel valid
//   in_h/s/v   hue (0..MAX spans 0..360 deg), saturation, value
//   in_mode    0 = HSV->RGB, 1 = bypass, 2 = greyscale, 3 = hue-only
//   in_user    sideband bits (e.g. {hsync, vsync, blank})
//   out_valid  output pixel valid
//   out_r/g/b  output channels; hold their last valid value on bubbles
//   out_region hue sector 0..5; 0 in bypass and greyscale modes
//   out_user   sideband delayed to match the pixel; updates on every beat
module hsv2rgb_stream #(
  parameter int DW     = 8,
  parameter int USER_W = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_h,
  input  logic [DW-1:0]     in_s,
  input  logic [DW-1:0]     in_v,
  input  logic [1:0]        in_mode,
  input  logic [USER_W-1:0] in_user,
  output logic              out_valid,
  output logic [DW-1:0]     out_r,
  output logic [DW-1:0]     out_g,
  output logic [DW-1:0]     out_b,
  output logic [2:0]        out_region,
  output logic [USER_W-1:0] out_user
);

  localparam logic [DW-1:0] MAX       = {DW{1'b1}};
  localparam logic [DW+2:0] SIX       = (DW+3)'(6);
  localparam logic [1:0]    MODE_HSV  = 2'd0;
  localparam logic [1:0]    MODE_BYP  = 2'd1;
  localparam logic [1:0]    MODE_GREY = 2'd2;
  localparam logic [1:0]    MODE_HUE  = 2'd3;

  // Full-width DW x DW product; operands are zero-extended explicitly.
  function automatic logic [2*DW-1:0] mul_dw(input logic [DW-1:0] a, input logic [DW-1:0] b);
    mul_dw = {{DW{1'b0}}, a} * {{DW{1'b0}}, b};
  endfunction

  // Per-beat fields carried through stages 1..5.
  logic [DW-1:0]     h_r    [1:5];
  logic [DW-1:0]     s_r    [1:5];
  logic [DW-1:0]     v_r    [1:5];
  logic [1:0]        mode_r [1:5];
  logic [USER_W-1:0] user_r [1:5];
  logic              vld_r  [1:5];
  logic [2:0]        region_r [2:5];

  // Stage-specific arithmetic registers.
  logic [DW-1:0]   f2_r, ns2_r;
  logic [2*DW-1:0] sf3_r, sfi3_r, pv3_r;
  logic [DW-1:0]   p4_r, qa4_r, ta4_r;
  logic [DW-1:0]   p5_r, q5_r, t5_r;

  // Combinational stage results.
  logic [DW-1:0]   s_in_s, v_in_s;
  logic [DW+2:0]   h6_s;
  logic [2*DW-1:0] qf_s, tf_s;
  logic [DW-1:0]   r_s, g_s, b_s;
  logic [2:0]      reg_s;

  // Hue-only mode forces full saturation and value at the pipeline entry.
  always_comb begin
    if (in_mode == MODE_HUE) begin
      s_in_s = MAX;
      v_in_s = MAX;
    end else begin
      s_in_s = in_s;
      v_in_s = in_v;
    end
  end

  // 6*h never exceeds 6*MAX < 6*2^DW, so the top three bits are the sector 0..5.
  always_comb begin
    h6_s = {3'b000, h_r[1]} * SIX;
    qf_s = mul_dw(v_r[4], qa4_r);
    tf_s = mul_dw(v_r[4], ta4_r);
  end

  // Pipeline stages 1..5: common fields shift, each stage adds its arithmetic.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 1; i <= 5; i++) begin
        h_r[i]    <= '0;
        s_r[i]    <= '0;
        v_r[i]    <= '0;
        mode_r[i] <= 2'd0;
        user_r[i] <= '0;
        vld_r[i]  <= 1'b0;
      end
      for (int i = 2; i <= 5; i++) region_r[i] <= 3'd0;
      f2_r   <= '0;
      ns2_r  <= '0;
      sf3_r  <= '0;
      sfi3_r <= '0;
      pv3_r  <= '0;
      p4_r   <= '0;
      qa4_r  <= '0;
      ta4_r  <= '0;
      p5_r   <= '0;
      q5_r   <= '0;
      t5_r   <= '0;
    end else if (en) begin
      h_r[1]    <= in_h;
      s_r[1]    <= s_in_s;
      v_r[1]    <= v_in_s;
      mode_r[1] <= in_mode;
      user_r[1] <= in_user;
      vld_r[1]  <= in_valid;
      for (int i = 2; i <= 5; i++) begin
        h_r[i]    <= h_r[i-1];
        s_r[i]    <= s_r[i-1];
        v_r[i]    <= v_r[i-1];
        mode_r[i] <= mode_r[i-1];
        user_r[i] <= user_r[i-1];
        vld_r[i]  <= vld_r[i-1];
      end
      region_r[2] <= h6_s[DW+2:DW];
      for (int i = 3; i <= 5; i++) region_r[i] <= region_r[i-1];
      f2_r   <= h6_s[DW-1:0];
      ns2_r  <= MAX - s_r[1];
      sf3_r  <= mul_dw(s_r[2], f2_r);
      sfi3_r <= mul_dw(s_r[2], MAX - f2_r);
      pv3_r  <= mul_dw(v_r[2], ns2_r);
      p4_r   <= pv3_r[2*DW-1:DW];
      qa4_r  <= MAX - sf3_r[2*DW-1:DW];
      ta4_r  <= MAX - sfi3_r[2*DW-1:DW];
      p5_r   <= p4_r;
      q5_r   <= qf_s[2*DW-1:DW];
      t5_r   <= tf_s[2*DW-1:DW];
    end
  end

  // Final stage: sector mapping, exact grey for s==0, and mode selection.
  always_comb begin
    r_s   = v_r[5];
    g_s   = v_r[5];
    b_s   = v_r[5];
    reg_s = 3'd0;
    case (mode_r[5])
      MODE_HSV, MODE_HUE: begin
        reg_s = region_r[5];
        if (s_r[5] == '0) begin
          r_s = v_r[5];
          g_s = v_r[5];
          b_s = v_r[5];
        end else begin
          case (region_r[5])
            3'd0:    begin r_s = v_r[5]; g_s = t5_r;   b_s = p5_r;   end
            3'd1:    begin r_s = q5_r;   g_s = v_r[5]; b_s = p5_r;   end
            3'd2:    begin r_s = p5_r;   g_s = v_r[5]; b_s = t5_r;   end
            3'd3:    begin r_s = p5_r;   g_s = q5_r;   b_s = v_r[5]; end
            3'd4:    begin r_s = t5_r;   g_s = p5_r;   b_s = v_r[5]; end
            3'd5:    begin r_s = v_r[5]; g_s = p5_r;   b_s = q5_r;   end
            default: begin r_s = v_r[5]; g_s = v_r[5]; b_s = v_r[5]; end
          endcase
        end
      end
      MODE_BYP: begin
        r_s = h_r[5];
        g_s = s_r[5];
        b_s = v_r[5];
      end
      MODE_GREY: begin
        r_s = v_r[5];
        g_s = v_r[5];
        b_s = v_r[5];
      end
      default: begin
        r_s = '0;
        g_s = '0;
        b_s = '0;
      end
    endcase
  end

  // Output register: pixel data only changes on valid beats, sideband always.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      out_r      <= '0;
      out_g      <= '0;
      out_b      <= '0;
      out_region <= 3'd0;
      out_user   <= '0;
    end else if (en) begin
      out_valid <= vld_r[5];
      out_user  <= user_r[5];
      if (vld_r[5]) begin
        out_r      <= r_s;
        out_g      <= g_s;
        out_b      <= b_s;
        out_region <= reg_s;
      end
    end
  end

endmodule

// File: tb/tb_hsv2rgb_stream.sv
module tb_hsv2rgb_stream;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_h = 8'd0, in_s = 8'd0, in_v = 8'd0;
  logic [1:0] in_mode = 2'd0;
  logic [2:0] in_user = 3'd0;
  logic       out_valid;
  logic [7:0] out_r, out_g, out_b;
  logic [2:0] out_region;
  logic [2:0] out_user;

  int n_cmp = 0;
  int n_bad = 0;

  hsv2rgb_stream #(.DW(8), .USER_W(3)) dut (
    .clk(clk), .rst(rst), .en(en), .in_valid(in_valid),
    .in_h(in_h), .in_s(in_s), .in_v(in_v), .in_mode(in_mode), .in_user(in_user),
    .out_valid(out_valid), .out_r(out_r), .out_g(out_g), .out_b(out_b),
    .out_region(out_region), .out_user(out_user)
  );

  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  // One beat, then bubbles; result checked after the 6th enabled edge.
  task automatic run_beat(input string name, input logic [7:0] h, input logic [7:0] s,
                          input logic [7:0] v, input logic [1:0] mode, input logic [2:0] user,
                          input logic [7:0] er, input logic [7:0] eg, input logic [7:0] eb,
                          input logic chk_reg, input logic [2:0] ereg);
    rst = 1'b0; en = 1'b1;
    in_h = h; in_s = s; in_v = v; in_mode = mode; in_user = user; in_valid = 1'b1;
    step;
    in_valid = 1'b0; in_user = 3'd6;
    repeat (5) step;
    n_cmp++; if (out_valid !== 1'b1) begin n_bad++; $display("FAIL %s valid: got %0d expected 1", name, out_valid); end
    n_cmp++; if (out_r !== er) begin n_bad++; $display("FAIL %s r: got %0d expected %0d", name, out_r, er); end
    n_cmp++; if (out_g !== eg) begin n_bad++; $display("FAIL %s g: got %0d expected %0d", name, out_g, eg); end
    n_cmp++; if (out_b !== eb) begin n_bad++; $display("FAIL %s b: got %0d expected %0d", name, out_b, eb); end
    n_cmp++; if (out_user !== user) begin n_bad++; $display("FAIL %s user: got %0d expected %0d", name, out_user, user); end
    if (chk_reg) begin
      n_cmp++; if (out_region !== ereg) begin n_bad++; $display("FAIL %s region: got %0d expected %0d", name, out_region, ereg); end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; en = 1'b1; in_valid = 1'b0;
    step; step;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL reset valid: got %0d expected 0", out_valid); end
    n_cmp++; if ({out_r, out_g, out_b} !== 24'd0) begin n_bad++; $display("FAIL reset rgb: got %0h expected 0", {out_r, out_g, out_b}); end
    n_cmp++; if (out_region !== 3'd0) begin n_bad++; $display("FAIL reset region: got %0d expected 0", out_region); end
    n_cmp++; if (out_user !== 3'd0) begin n_bad++; $display("FAIL reset user: got %0d expected 0", out_user); end
  endtask

  task automatic test_hsv;
    // Released from reset in the same cycle the first beat is presented.
    run_beat("red",     8'd0,   8'd255, 8'd255, 2'd0, 3'd1, 8'd255, 8'd0,   8'd0, 1'b1, 3'd0);
    run_beat("h128",    8'd128, 8'd255, 8'd255, 2'd0, 3'd2, 8'd0,   8'd254, 8'd255, 1'b1, 3'd3);
    run_beat("hmax",    8'd255, 8'd255, 8'd255, 2'd0, 3'd3, 8'd255, 8'd0,   8'd5, 1'b1, 3'd5);
    run_beat("s_zero",  8'd77,  8'd0,   8'd200, 2'd0, 3'd4, 8'd200, 8'd200, 8'd200, 1'b0, 3'd0);
    run_beat("bypass",  8'd12,  8'd34,  8'd56,  2'd1, 3'd5, 8'd12,  8'd34,  8'd56, 1'b1, 3'd0);
    run_beat("grey",    8'd12,  8'd34,  8'd93,  2'd2, 3'd6, 8'd93,  8'd93,  8'd93, 1'b1, 3'd0);
    run_beat("hue_only", 8'd128, 8'd7,  8'd9,   2'd3, 3'd7, 8'd0,   8'd254, 8'd255, 1'b1, 3'd3);
  endtask

  task automatic test_bubble;
    run_beat("pre_bubble", 8'd0, 8'd255, 8'd255, 2'd0, 3'd5, 8'd255, 8'd0, 8'd0, 1'b1, 3'd0);
    step;
    n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL bubble valid: got %0d expected 0", out_valid); end
    n_cmp++; if ({out_r, out_g, out_b} !== 24'hFF0000) begin n_bad++; $display("FAIL bubble hold: got %0h expected ff0000", {out_r, out_g, out_b}); end
    n_cmp++; if (out_user !== 3'd6) begin n_bad++; $display("FAIL bubble user: got %0d expected 6", out_user); end
  endtask

  task automatic test_mode_switch;
    logic [7:0] eh [4];
    logic [7:0] es [4];
    logic [7:0] ev [4];
    logic [1:0] em [4];
    logic [7:0] er [4];
    logic [7:0] eg [4];
    logic [7:0] eb [4];
    logic [2:0] ereg [4];
    eh = '{8'd0, 8'd12, 8'd12, 8'd128}; es = '{8'd255, 8'd34, 8'd34, 8'd7};
    ev = '{8'd255, 8'd56, 8'd93, 8'd9}; em = '{2'd0, 2'd1, 2'd2, 2'd3};
    er = '{8'd255, 8'd12, 8'd93, 8'd0}; eg = '{8'd0, 8'd34, 8'd93, 8'd254};
    eb = '{8'd0, 8'd56, 8'd93, 8'd255}; ereg = '{3'd0, 3'd0, 3'd0, 3'd3};
    rst = 1'b0; en = 1'b1;
    for (int c = 0; c < 9; c++) begin
      if (c < 4) begin
        in_valid = 1'b1; in_h = eh[c]; in_s = es[c]; in_v = ev[c]; in_mode = em[c]; in_user = 3'(c);
      end else begin
        in_valid = 1'b0; in_mode = 2'd0;
      end
      step;
      if (c >= 5) begin
        n_cmp++; if ({out_valid, out_r, out_g, out_b, out_region, out_user} !== {1'b1, er[c-5], eg[c-5], eb[c-5], ereg[c-5], 3'(c-5)}) begin
          n_bad++;
          $display("FAIL mode_switch beat %0d: got v=%0d rgb=%0h reg=%0d u=%0d expected rgb=%0h reg=%0d u=%0d",
                   c-5, out_valid, {out_r, out_g, out_b}, out_region, out_user, {er[c-5], eg[c-5], eb[c-5]}, ereg[c-5], c-5);
        end
      end
    end
  endtask

  task automatic test_back_to_back;
    int got;
    logic [7:0] xh, xs, xv;
    got = 0;
    rst = 1'b0; in_mode = 2'd1;
    for (int c = 0; c < 30; c++) begin
      int b;
      b = (c < 8) ? c : ((c < 11) ? 8 : c - 3);
      en = !(c >= 8 && c <= 10);
      in_valid = (b < 10);
      in_h = 8'(b * 20 + 3); in_s = 8'(b + 1); in_v = 8'(200 - b); in_user = 3'(b);
      step;
      if (!en) begin
        n_cmp++; if ({out_valid, out_r, out_g, out_b, out_user} !== {1'b1, 8'd43, 8'd3, 8'd198, 3'd2}) begin
          n_bad++; $display("FAIL stall_hold cycle %0d: got v=%0d rgb=%0h u=%0d expected 1 2b03c6 2", c, out_valid, {out_r, out_g, out_b}, out_user);
        end
      end else if (out_valid) begin
        xh = 8'(got * 20 + 3); xs = 8'(got + 1); xv = 8'(200 - got);
        n_cmp++; if ({out_r, out_g, out_b, out_user} !== {xh, xs, xv, 3'(got)}) begin
          n_bad++; $display("FAIL stream beat %0d: got rgb=%0h u=%0d expected rgb=%0h u=%0d", got, {out_r, out_g, out_b}, out_user, {xh, xs, xv}, got[2:0]);
        end
        got++;
      end
    end
    en = 1'b1;
    n_cmp++; if (got !== 10) begin n_bad++; $display("FAIL stream count: got %0d expected 10", got); end
  endtask

  task automatic test_reset_in_flight;
    rst = 1'b0; en = 1'b1; in_mode = 2'd0;
    for (int c = 0; c < 4; c++) begin
      in_valid = 1'b1; in_h = 8'd0; in_s = 8'd255; in_v = 8'd255; in_user = 3'd5;
      step;
    end
    in_valid = 1'b0; in_user = 3'd0; rst = 1'b1;
    step;
    n_cmp++; if ({out_valid, out_r, out_g, out_b, out_region, out_user} !== 31'd0) begin
      n_bad++; $display("FAIL flight_reset: got v=%0d rgb=%0h reg=%0d u=%0d expected all 0", out_valid, {out_r, out_g, out_b}, out_region, out_user);
    end
    rst = 1'b0;
    for (int c = 0; c < 8; c++) begin
      step;
      n_cmp++; if (out_valid !== 1'b0) begin n_bad++; $display("FAIL flight_discard cycle %0d: got valid %0d expected 0", c, out_valid); end
    end
    run_beat("after_reset", 8'd128, 8'd255, 8'd255, 2'd0, 3'd3, 8'd0, 8'd254, 8'd255, 1'b1, 3'd3);
  endtask

  task automatic test_reset_no_en;
    run_beat("pre_rst_noen", 8'd255, 8'd255, 8'd255, 2'd0, 3'd2, 8'd255, 8'd0, 8'd5, 1'b1, 3'd5);
    rst = 1'b1; en = 1'b0;
    step;
    n_cmp++; if ({out_valid, out_r, out_b, out_region} !== 20'd0) begin
      n_bad++; $display("FAIL rst_noen: got v=%0d r=%0d b=%0d reg=%0d expected all 0", out_valid, out_r, out_b, out_region);
    end
    rst = 1'b0; en = 1'b1;
  endtask

  initial begin
    test_reset;
    test_hsv;
    test_bubble;
    test_mode_switch;
    test_back_to_back;
    test_reset_in_flight;
    test_reset_no_en;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/hsv2rgb_stream.md
Name: hsv2rgb_stream

Overview:
Parametrised, streaming successor to the existing fixed 8-bit HSV-to-RGB converter. It converts one HSV pixel per enabled clock using integer math in a fixed 6-stage pipeline. It adds a valid flag, a global stall/enable, a run-time mode select, a sideband pass-through (sync/blank bits) and an exact grey path for s==0. It sits between the colour-generation logic and the VGA/video output stage.

Parameters:
DW, 8, channel width in bits for h, s, v, r, g, b; MAX = 2^DW-1.
USER_W, 3, width of the sideband bus carried alongside the pixel, e.g. {hsync, vsync, blank}.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
en  input  1  pipeline enable; 0 = every stage holds
in_valid  input  1  input pixel valid
in_h  input  DW  hue, full range 0..MAX maps to 0..360 deg
in_s  input  DW  saturation
in_v  input  DW  value
in_mode  input  2  0=HSV->RGB, 1=bypass, 2=greyscale, 3=hue-only
in_user  input  USER_W  sideband, delayed to match the data path
out_valid  output  1  output pixel valid
out_r  output  DW  red
out_g  output  DW  green
out_b  output  DW  blue
out_region  output  3  hue sector 0..5 of the emitted pixel; 0 in modes 1 and 2
out_user  output  USER_W  delayed sideband

Behaviour:
- Reset: synchronous on rst=1 at a clk edge. It clears all stage valid bits, out_valid, out_r/g/b, out_region and out_user to 0. Reset overrides en. Beats in flight are discarded, not flushed.
- Pipeline advance: stages advance only on edges with en=1. With en=0, all registers, including outputs, hold.
- Latency: a beat captured on enabled edge k appears on the outputs after enabled edge k+5, i.e. 6 enabled edges including the capture edge. Throughput is 1 beat per enabled cycle. Mode and user travel with their own beat.
- Bubbles: in_valid=0 beats propagate as bubbles. When a bubble reaches the output, out_valid=0 and out_r/g/b/region hold their last valid values. out_user always updates, because sync bits matter during blanking.
- Stage 1: register h, s, v, mode, user, valid.
- Stage 2:
  - h6 = 6*h, width DW+3.
  - region = h6 >> DW, range 0..5.
  - f = h6[DW-1:0].
  - ns = MAX - s.
- Stage 3:
  - sf = s*f.
  - sfi = s*(MAX-f).
  - pv = v*ns.
  - All products are 2*DW bits.
- Stage 4:
  - p = pv >> DW.
  - qa = MAX - (sf >> DW).
  - ta = MAX - (sfi >> DW).
- Stage 5: q = (v*qa) >> DW and t = (v*ta) >> DW. All right-shifts truncate; there is no rounding.
- Stage 6, mode 0, sector mapping as (r,g,b):
  - 0: (v,t,p)
  - 1: (q,v,p)
  - 2: (p,v,t)
  - 3: (p,q,v)
  - 4: (t,p,v)
  - 5: (v,p,q)
- Stage 6, mode 0, s==0 override: output exactly (v,v,v) regardless of region.
- Stage 6, other modes:
  - Mode 1 outputs (h,s,v) unchanged.
  - Mode 2 outputs (v,v,v).
  - Mode 3 recomputes with s=MAX and v=MAX internally. Substitute these values at stage 1.
- Boundaries:
  - h=0 gives region 0.
  - h=MAX gives region 5 with f = 6*MAX - 5*2^DW.
  - region never exceeds 5 for any DW.
  - in_mode changes between consecutive beats take effect per beat, with no glitch on neighbouring beats.
  - rst asserted together with en=0 still resets.
  - Deasserting rst with in_valid=1 on the same edge accepts that beat.

Test Plan:
1. DW=8, mode 0, (h,s,v) = (0,255,255) → after 6 enabled edges: out_valid=1, (255,0,0), region 0.
2. DW=8, mode 0:
   - (128,255,255) → (0,254,255), region 3.
   - (255,255,255) → (255,0,5), region 5.
3. Mode 0, (77,0,200) → (200,200,200) via the s==0 override.
4. Mode 1, (12,34,56) → (12,34,56), region 0. Mode 2, (12,34,93) → (93,93,93).
5. Back-to-back stream of 10 valid beats; drop en for 3 cycles mid-stream:
   - exactly 10 outputs, in order, no duplicates.
   - outputs frozen during the stall.
   - out_user stays aligned with its pixel.
6. rst pulse while 4 beats are in flight → next edge: out_valid=0 and outputs 0; none of the 4 beats ever emerges. A new beat after reset emerges at normal latency.
